// File: rtl/mac_neuron.sv
// Time-multiplexed FP32 weighted-sum neuron on one multiplier and one adder.
// Build option: NEURON_BIAS_EN seeds the accumulator with iBIAS.

module fp_multiplier #(
    parameter int LAT = 5
) (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    function automatic logic [31:0] fpMul(input logic [31:0] p, input logic [31:0] q);
        logic [7:0]  ea, eb;
        logic [22:0] ma, mb;
        logic        s, g, st, rnd;
        logic [47:0] pr;
        logic [23:0] m;
        logic [24:0] mr;
        logic [9:0]  e;
        logic [31:0] r;
        ea = p[30:23];
        eb = q[30:23];
        ma = p[22:0];
        mb = q[22:0];
        s  = p[31] ^ q[31];
        r  = {s, 31'b0};
        if ((ea == 8'hFF && ma != 0) || (eb == 8'hFF && mb != 0) ||
            (ea == 8'hFF && eb == 0) || (eb == 8'hFF && ea == 0)) begin
            r = 32'h7FC0_0000;
        end else if (ea == 8'hFF || eb == 8'hFF) begin
            r = {s, 8'hFF, 23'b0};
        end else if (ea != 0 && eb != 0) begin
            pr = {1'b1, ma} * {1'b1, mb};
            e  = {2'b0, ea} + {2'b0, eb} - 10'd127;
            if (pr[47]) begin
                m  = pr[47:24];
                g  = pr[23];
                st = |pr[22:0];
                e  = e + 10'd1;
            end else begin
                m  = pr[46:23];
                g  = pr[22];
                st = |pr[21:0];
            end
            rnd = g & (st | m[0]);
            mr  = {1'b0, m} + {24'b0, rnd};
            if (mr[24]) e = e + 10'd1;
            if (e[9] || e == 0) r = {s, 31'b0};
            else if (e >= 10'd255) r = {s, 8'hFF, 23'b0};
            else r = {s, e[7:0], mr[24] ? 23'b0 : mr[22:0]};
        end
        return r;
    endfunction

    logic [31:0] pipe [LAT];

    always_ff @(posedge clk) begin
        pipe[0] <= fpMul(a, b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign y = pipe[LAT-1];

endmodule

module fp_adder #(
    parameter int LAT = 7
) (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    function automatic logic [31:0] fpAdd(input logic [31:0] p, input logic [31:0] q);
        logic [31:0] u, v, x, z, r;
        logic [26:0] mx, my, sh;
        logic [27:0] s;
        logic [9:0]  e;
        logic [7:0]  d;
        logic [4:0]  lz;
        logic [24:0] mr;
        logic        found, rnd;
        // Denormals are flushed to signed zero before alignment.
        u = (p[30:23] == 0) ? {p[31], 31'b0} : p;
        v = (q[30:23] == 0) ? {q[31], 31'b0} : q;
        if (u[30:0] >= v[30:0]) begin
            x = u;
            z = v;
        end else begin
            x = v;
            z = u;
        end
        r = x;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 0 || (z[30:23] == 8'hFF && z[31] != x[31]))
                r = 32'h7FC0_0000;
        end else if (z[30:23] != 0) begin
            d  = x[30:23] - z[30:23];
            mx = {1'b1, x[22:0], 3'b0};
            my = {1'b1, z[22:0], 3'b0};
            if (d > 8'd26) begin
                sh = 27'd1;
            end else begin
                sh    = my >> d;
                sh[0] = sh[0] | (|(my & ((27'd1 << d) - 27'd1)));
            end
            if (x[31] == z[31]) s = {1'b0, mx} + {1'b0, sh};
            else s = {1'b0, mx} - {1'b0, sh};
            e = {2'b0, x[30:23]};
            if (s == 0) begin
                r = 32'h0;
            end else begin
                if (s[27]) begin
                    s = {1'b0, s[27:2], s[1] | s[0]};
                    e = e + 10'd1;
                end else begin
                    lz    = 5'd0;
                    found = 1'b0;
                    for (int i = 26; i >= 0; i--) begin
                        if (!found) begin
                            if (s[i]) found = 1'b1;
                            else lz = lz + 5'd1;
                        end
                    end
                    s = s << lz;
                    e = e - {5'b0, lz};
                end
                rnd = s[2] & (s[1] | s[0] | s[3]);
                mr  = {1'b0, s[26:3]} + {24'b0, rnd};
                if (mr[24]) e = e + 10'd1;
                if (e[9] || e == 0) r = {x[31], 31'b0};
                else if (e >= 10'd255) r = {x[31], 8'hFF, 23'b0};
                else r = {x[31], e[7:0], mr[24] ? 23'b0 : mr[22:0]};
            end
        end
        return r;
    endfunction

    logic [31:0] pipe [LAT];

    always_ff @(posedge clk) begin
        pipe[0] <= fpAdd(a, b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign y = pipe[LAT-1];

endmodule

module mac_neuron #(
    parameter int N_IN    = 4,
    parameter int MUL_LAT = 5,
    parameter int ADD_LAT = 7
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSTART,
    input  logic [N_IN*32-1:0] iX,
    input  logic [N_IN*32-1:0] iW,
    input  logic [31:0]      iBIAS,
    output logic             oREADY,
    output logic             oBUSY,
    output logic             oVALID,
    output logic [31:0]      oSUM
);

    localparam int CW = $clog2(N_IN + 1);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
`ifdef NEURON_BIAS_EN
    localparam int N_ADD = N_IN;
`else
    localparam int N_ADD = N_IN - 1;
`endif
    localparam logic [CW-1:0] LAST = CW'(N_IN - 1);
    localparam logic [CW-1:0] NADD = CW'(N_ADD);

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} stateT;

    stateT              state;
    logic [31:0]        xReg [N_IN];
    logic [31:0]        wReg [N_IN];
    logic [31:0]        prod [N_IN];
    logic [31:0]        acc;
    logic [CW-1:0]      issCnt, prodCnt, addCnt;
    logic [MUL_LAT-1:0] mulVld;
    logic [ADD_LAT-1:0] addVld;
    logic               addBusy;
    logic               mulIssue, addIssue, mulRet, addRet;
    logic [IW-1:0]      prodSel;
    logic [31:0]        mulY, addA, addB, addY, seed;

`ifdef NEURON_BIAS_EN
    logic [31:0] biasReg;
    assign seed    = biasReg;
    assign prodSel = addCnt[IW-1:0];
`else
    logic unusedBias;
    assign unusedBias = ^iBIAS;
    assign seed       = (N_IN == 1) ? mulY : prod[0];
    assign prodSel    = addCnt[IW-1:0] + IW'(1);
`endif

    assign mulIssue = (state == MUL) && (issCnt != CW'(N_IN));
    assign mulRet   = mulVld[MUL_LAT-1];
    assign addRet   = addVld[ADD_LAT-1];
    // Next addition chains straight off the returning sum to avoid a bubble.
    assign addIssue = (state == ACC) && (addCnt != NADD) && (!addBusy || addRet);
    assign addA     = addRet ? addY : acc;
    assign addB     = prod[prodSel];

    fp_multiplier #(.LAT(MUL_LAT)) uMul (
        .clk (iCLK),
        .a   (xReg[issCnt[IW-1:0]]),
        .b   (wReg[issCnt[IW-1:0]]),
        .y   (mulY)
    );

    fp_adder #(.LAT(ADD_LAT)) uAdd (
        .clk (iCLK),
        .a   (addA),
        .b   (addB),
        .y   (addY)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= IDLE;
            oREADY  <= 1'b1;
            oBUSY   <= 1'b0;
            oVALID  <= 1'b0;
            oSUM    <= '0;
            acc     <= '0;
            issCnt  <= '0;
            prodCnt <= '0;
            addCnt  <= '0;
            addBusy <= 1'b0;
            mulVld  <= '0;
            addVld  <= '0;
            for (int k = 0; k < N_IN; k++) begin
                xReg[k] <= '0;
                wReg[k] <= '0;
                prod[k] <= '0;
            end
`ifdef NEURON_BIAS_EN
            biasReg <= '0;
`endif
        end else begin
            mulVld <= (mulVld << 1) | MUL_LAT'(mulIssue);
            addVld <= (addVld << 1) | ADD_LAT'(addIssue);
            oVALID <= 1'b0;
            if (mulIssue) issCnt <= issCnt + 1'b1;
            if (mulRet) begin
                prod[prodCnt[IW-1:0]] <= mulY;
                prodCnt <= prodCnt + 1'b1;
            end
            if (addIssue) begin
                addCnt  <= addCnt + 1'b1;
                addBusy <= 1'b1;
            end else if (addRet) begin
                addBusy <= 1'b0;
            end
            if (addRet) acc <= addY;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (iSTART) begin
                        for (int k = 0; k < N_IN; k++) begin
                            xReg[k] <= iX[32*k +: 32];
                            wReg[k] <= iW[32*k +: 32];
                        end
`ifdef NEURON_BIAS_EN
                        biasReg <= iBIAS;
`endif
                        issCnt  <= '0;
                        prodCnt <= '0;
                        addCnt  <= '0;
                        addBusy <= 1'b0;
                        state   <= MUL;
                        oREADY  <= 1'b0;
                        oBUSY   <= 1'b1;
                    end
                end
                MUL: begin
                    if (mulRet && prodCnt == LAST) begin
                        acc   <= seed;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (addRet && addCnt == NADD) begin
                        oSUM   <= addY;
                        oVALID <= 1'b1;
                        oBUSY  <= 1'b0;
                        oREADY <= 1'b1;
                        state  <= DONE;
                    end else if (NADD == 0) begin
                        oSUM   <= acc;
                        oVALID <= 1'b1;
                        oBUSY  <= 1'b0;
                        oREADY <= 1'b1;
                        state  <= DONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_neuron.sv
// Directed bench for mac_neuron: four-input and single-input instances.
// Expectations follow NEURON_BIAS_EN when it is defined for the build.

module tb_mac_neuron;

`ifdef NEURON_BIAS_EN
    localparam int          L4 = 38;
    localparam int          L1 = 14;
    localparam logic [31:0] S1 = 32'h0000_0000;
    localparam logic [31:0] S2 = 32'h3FE0_0000;
    localparam logic [31:0] S5 = 32'h4088_0000;
`else
    localparam int          L4 = 31;
    localparam int          L1 = 7;
    localparam logic [31:0] S1 = 32'h3FE0_0000;
    localparam logic [31:0] S2 = 32'h4060_0000;
    localparam logic [31:0] S5 = 32'h40C0_0000;
`endif

    localparam logic [127:0] ONES = {4{32'h3F80_0000}};
    localparam logic [127:0] TWOS = {4{32'h4000_0000}};
    localparam logic [127:0] WV   = {32'h3E80_0000, 32'hBF80_0000,
                                     32'h4000_0000, 32'h3F00_0000};

    logic         clk = 1'b0;
    logic         rstN;
    logic         start, start1;
    logic [127:0] x, w;
    logic [31:0]  x1, w1, bias;
    logic         rdy, busy, vld, rdy1, busy1, vld1;
    logic [31:0]  sum, sum1;

    int nChk  = 0;
    int nPass = 0;
    int lat, extra;
    bit busyDrop;

    always #5 clk = ~clk;

    mac_neuron #(.N_IN(4), .MUL_LAT(5), .ADD_LAT(7)) u0 (
        .iCLK   (clk),
        .iRST_N (rstN),
        .iSTART (start),
        .iX     (x),
        .iW     (w),
        .iBIAS  (bias),
        .oREADY (rdy),
        .oBUSY  (busy),
        .oVALID (vld),
        .oSUM   (sum)
    );

    mac_neuron #(.N_IN(1), .MUL_LAT(5), .ADD_LAT(7)) u1 (
        .iCLK   (clk),
        .iRST_N (rstN),
        .iSTART (start1),
        .iX     (x1),
        .iW     (w1),
        .iBIAS  (bias),
        .oREADY (rdy1),
        .oBUSY  (busy1),
        .oVALID (vld1),
        .oSUM   (sum1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Counts edges after the accepting edge until oVALID; -1 if none within budget.
    task automatic waitValid(input int pokeAt, output int n0, output bit drop);
        n0   = -1;
        drop = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            if (vld) begin
                n0 = n;
                break;
            end
            if (!busy) drop = 1'b1;
            if (pokeAt > 0) start = (n == pokeAt);
        end
    endtask

    task automatic acceptEdge();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rstN   = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        x      = ONES;
        w      = WV;
        x1     = 32'h4040_0000;
        w1     = 32'h4000_0000;
        bias   = 32'hBFE0_0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(rdy), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(vld), 32'd0);
        check("rst_sum", sum, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        // single job
        @(negedge clk);
        start = 1'b1;
        acceptEdge();
        check("t1_busy0", 32'(busy), 32'd1);
        check("t1_ready0", 32'(rdy), 32'd0);
        waitValid(-1, lat, busyDrop);
        check("t1_lat", 32'(lat), 32'(L4));
        check("t1_sum", sum, S1);
        check("t1_busyheld", 32'(busyDrop), 32'd0);
        check("t1_busydone", 32'(busy), 32'd0);
        check("t1_readydone", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        check("t1_pulse", 32'(vld), 32'd0);
        check("t1_hold", sum, S1);

        // start held high across two jobs; inputs swapped after first accept
        @(negedge clk);
        x     = ONES;
        start = 1'b1;
        @(posedge clk);
        #1;
        x = TWOS;
        waitValid(-1, lat, busyDrop);
        check("t2_lat1", 32'(lat), 32'(L4));
        check("t2_sum1", sum, S1);
        waitValid(-1, lat, busyDrop);
        start = 1'b0;
        check("t2_lat2", 32'(lat), 32'(L4 + 1));
        check("t2_sum2", sum, S2);
        @(posedge clk);
        #1;
        check("t2_pulse", 32'(vld), 32'd0);
        @(posedge clk);
        #1;
        check("t2_idle", 32'(busy), 32'd0);

        // stray start during a job
        @(negedge clk);
        x     = ONES;
        start = 1'b1;
        acceptEdge();
        waitValid(10, lat, busyDrop);
        start = 1'b0;
        check("t3_lat", 32'(lat), 32'(L4));
        check("t3_sum", sum, S1);
        extra = 0;
        for (int n = 0; n < 45; n++) begin
            @(posedge clk);
            #1;
            if (vld) extra++;
        end
        check("t3_extra", 32'(extra), 32'd0);

        // reset in the middle of a job
        @(negedge clk);
        x     = TWOS;
        start = 1'b1;
        acceptEdge();
        repeat (15) @(posedge clk);
        #1;
        rstN = 1'b0;
        #2;
        check("t4_rst_sum", sum, 32'h0);
        check("t4_rst_ready", 32'(rdy), 32'd1);
        check("t4_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstN  = 1'b1;
        extra = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (vld) extra++;
        end
        check("t4_novalid", 32'(extra), 32'd0);
        check("t4_sum0", sum, 32'h0);
        check("t4_ready", 32'(rdy), 32'd1);
        @(negedge clk);
        x     = ONES;
        start = 1'b1;
        acceptEdge();
        waitValid(-1, lat, busyDrop);
        check("t4_lat", 32'(lat), 32'(L4));
        check("t4_sum", sum, S1);

        // single-input neuron
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        lat    = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (vld1) begin
                lat = n;
                break;
            end
        end
        check("t5_lat", 32'(lat), 32'(L1));
        check("t5_sum", sum1, S5);
        check("t5_ready", 32'(rdy1), 32'd1);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
